// File: rtl/rt_cmd_pkg.sv
// Shared types for the real-time command scheduler: payload layout, table entry and FSM states.
package rt_cmd_pkg;

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] freq_step;
    logic [31:0] freq_rate;
    logic [15:0] n_impuls;
    logic [1:0]  cmd_type;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_payload_t;

  localparam int unsigned CMD_PAYLOAD_W = $bits(cmd_payload_t);

  typedef struct packed {
    logic         valid;
    logic [63:0]  tstart;
    cmd_payload_t payload;
  } cmd_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StIssue
  } sched_state_t;

endpackage

// File: rtl/rt_slot_alloc.sv
// Lowest-index free slot finder plus full flag over the slot valid vector.
module rt_slot_alloc #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid_i,
  output logic [IW-1:0]    free_idx_o,
  output logic             full_o
);

  // Walk downwards so the lowest free index is the last one assigned.
  always_comb begin
    free_idx_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_i[i]) free_idx_o = IW'(i);
    end
  end

  assign full_o = &valid_i;

endmodule

// File: rtl/rt_cmd_sched.sv
// Timed command table: two writers, issues the earliest non-stale command per request,
// purges stale entries during the scan and flushes on a system-time resync.
module rt_cmd_sched
  import rt_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GUARD = 16,
  parameter int unsigned PW    = CMD_PAYLOAD_W,
  localparam int unsigned IW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [63:0]   time_i,
  input  logic          time_resync_i,
  input  logic          wr_a_i,
  input  logic [63:0]   tstart_a_i,
  input  logic [PW-1:0] payload_a_i,
  output logic          rdy_a_o,
  input  logic          wr_b_i,
  input  logic [63:0]   tstart_b_i,
  input  logic [PW-1:0] payload_b_i,
  output logic          rdy_b_o,
  input  logic          req_command_i,
  output logic          data_wr_o,
  output logic [63:0]   time_start_z_o,
  output logic [PW-1:0] payload_z_o,
  output logic [CW-1:0] count_o,
  output logic          stale_drop_o,
  output logic          flushed_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [63:0]      tstart_q  [DEPTH];
  logic [PW-1:0]    payload_q [DEPTH];

  sched_state_t  state_q, state_d;
  logic          pending_q, pending_d, req_q;
  logic [IW-1:0] scan_idx_q, scan_idx_d, best_idx_q, best_idx_d;
  logic [63:0]   best_t_q, best_t_d;
  logic          best_found_q, best_found_d;
  logic          data_wr_q, data_wr_d, stale_drop_q, stale_drop_d, flushed_q;
  logic [63:0]   tz_q;
  logic [PW-1:0] pz_q;

  logic [IW-1:0] free_idx;
  logic          full, wr_a_acc, wr_b_acc, wr_acc;
  logic [CW-1:0] cnt;
  logic [64:0]   limit;
  logic [63:0]   cur_t;
  logic          cur_stale, better;

  rt_slot_alloc #(.DEPTH(DEPTH)) u_alloc (
    .valid_i    (valid_q),
    .free_idx_o (free_idx),
    .full_o     (full)
  );

  assign rdy_a_o  = !rst_i && (state_q == StIdle) && !full && !time_resync_i;
  assign rdy_b_o  = rdy_a_o && !wr_a_i;
  assign wr_a_acc = wr_a_i && rdy_a_o;
  assign wr_b_acc = wr_b_i && rdy_b_o;
  assign wr_acc   = wr_a_acc || wr_b_acc;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(valid_q[i]);
  end

  // 65-bit limit: a carry out means TIME+GUARD wrapped and every entry is stale.
  assign limit     = {1'b0, time_i} + 65'(GUARD);
  assign cur_t     = tstart_q[scan_idx_q];
  assign cur_stale = {1'b0, cur_t} < limit;
  assign better    = !best_found_q || (cur_t < best_t_q);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    pending_d    = pending_q | (req_command_i & ~req_q);
    scan_idx_d   = scan_idx_q;
    best_idx_d   = best_idx_q;
    best_t_d     = best_t_q;
    best_found_d = best_found_q;
    data_wr_d    = 1'b0;
    stale_drop_d = 1'b0;
    if (wr_acc) valid_d[free_idx] = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (pending_q && (cnt != '0) && !wr_acc) begin
          state_d      = StScan;
          scan_idx_d   = '0;
          best_found_d = 1'b0;
        end
      end
      StScan: begin
        if (valid_q[scan_idx_q]) begin
          if (cur_stale) begin
            valid_d[scan_idx_q] = 1'b0;
            stale_drop_d        = 1'b1;
          end else if (better) begin
            best_found_d = 1'b1;
            best_idx_d   = scan_idx_q;
            best_t_d     = cur_t;
          end
        end
        if (scan_idx_q == IW'(DEPTH - 1)) begin
          state_d = best_found_d ? StIssue : StIdle;
        end else begin
          scan_idx_d = scan_idx_q + IW'(1);
        end
      end
      StIssue: begin
        valid_d[best_idx_q] = 1'b0;
        pending_d           = 1'b0;
        data_wr_d           = 1'b1;
        state_d             = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Resync wins over everything except an issue already under way.
    if (time_resync_i) begin
      valid_d      = '0;
      state_d      = StIdle;
      stale_drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      pending_q    <= 1'b0;
      req_q        <= 1'b0;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_t_q     <= '0;
      best_found_q <= 1'b0;
      data_wr_q    <= 1'b0;
      stale_drop_q <= 1'b0;
      flushed_q    <= 1'b0;
      tz_q         <= '0;
      pz_q         <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      pending_q    <= pending_d;
      req_q        <= req_command_i;
      scan_idx_q   <= scan_idx_d;
      best_idx_q   <= best_idx_d;
      best_t_q     <= best_t_d;
      best_found_q <= best_found_d;
      data_wr_q    <= data_wr_d;
      stale_drop_q <= stale_drop_d;
      flushed_q    <= time_resync_i;
      if (state_q == StIssue) begin
        tz_q <= tstart_q[best_idx_q];
        pz_q <= payload_q[best_idx_q];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      tstart_q[free_idx]  <= wr_a_acc ? tstart_a_i : tstart_b_i;
      payload_q[free_idx] <= wr_a_acc ? payload_a_i : payload_b_i;
    end
  end

  assign data_wr_o      = data_wr_q;
  assign time_start_z_o = tz_q;
  assign payload_z_o    = pz_q;
  assign count_o        = cnt;
  assign stale_drop_o   = stale_drop_q;
  assign flushed_o      = flushed_q;

endmodule

// File: doc/rt_cmd_sched.md
Name: rt_cmd_sched

Overview:
- Real-time command scheduler between the command sources and the MASTER_START synchronizer.
- Accepts timed commands (TIME_START plus DDS/pulse-train payload) from two writers: A = MCU/SPI path, high priority; B = local/auto source.
- Stores them in a small unordered table. On each synchronizer REQ_COMMAND it issues the earliest still-valid command.
- Purges stale commands, and flushes the table when system time is re-set at the second mark.

Parameters:
- DEPTH, 8: number of command slots (power of 2, 2..16).
- GUARD, 16: minimum lead in CLK cycles; a command with TIME_START < TIME+GUARD is stale.
- PW, CMD_PAYLOAD_W from the package (274): payload width. Payload = FREQ48, FREQ_STEP48, FREQ_RATE32, N_impuls16, TYPE2, Ti32, Tp32, Tblank1 32, Tblank2 32.

Ports:
- CLK  in  1  system clock (48 MHz domain)
- RESET  in  1  asynchronous, active-high reset
- TIME  in  64  current system time from the synchronizer
- TIME_RESYNC  in  1  one-cycle pulse: system time was re-set (SYS_TIME_UPDATE_OK rising edge)
- WR_A  in  1  write strobe, source A
- TSTART_A  in  64  start time, source A
- PAYLOAD_A  in  PW  payload, source A
- RDY_A  out  1  source A may write this cycle
- WR_B, TSTART_B, PAYLOAD_B, RDY_B: same set for source B
- REQ_COMMAND  in  1  synchronizer requests next command (pulse or level; rising edge used)
- DATA_WR  out  1  one-cycle strobe: TIME_START_z / PAYLOAD_z valid
- TIME_START_z  out  64  issued start time
- PAYLOAD_z  out  PW  issued payload
- COUNT  out  $clog2(DEPTH)+1  occupied slots
- STALE_DROP  out  1  one-cycle pulse per stale entry discarded
- FLUSHED  out  1  one-cycle pulse after a resync flush

Behaviour:
- Reset (async, RESET=1):
  - all slot valid bits cleared; state IDLE; request-pending flag cleared.
  - all outputs 0; RDY_A/RDY_B 0 while RESET is high.
- Write acceptance:
  - RDY_A = state==IDLE && !full && !TIME_RESYNC.
  - RDY_B = RDY_A && !WR_A (A wins a simultaneous write; B must hold its write).
  - An accepted write stores into the lowest-index free slot and sets its valid bit; COUNT updates the next cycle.
  - A write while RDY is low is ignored; no error flag.
- Request latch: a REQ_COMMAND rising edge sets the pending flag. Extra edges while pending are absorbed.
- FSM states IDLE, SCAN, ISSUE.
  - IDLE -> SCAN when pending && COUNT>0 && no write accepted this cycle.
  - SCAN: examines one slot per cycle, index 0..DEPTH-1.
    - Valid slot with TIME_START < TIME+GUARD: valid cleared, STALE_DROP pulsed.
    - Otherwise the slot becomes the best candidate if its TIME_START is strictly less than the current best. Equal times: lower index wins.
  - SCAN -> ISSUE after slot DEPTH-1 if a candidate was found; otherwise -> IDLE with pending kept.
  - ISSUE (1 cycle):
    - DATA_WR=1 with the candidate's fields; candidate slot invalidated; pending cleared.
    - TIME_START_z/PAYLOAD_z hold their value until the next ISSUE.
    - ISSUE -> IDLE.
- Latency:
  - REQ edge with an idle table -> DATA_WR exactly DEPTH+2 cycles later (1 latch, DEPTH scan, 1 issue).
  - A request pending on an empty table is served DEPTH+2 cycles after the first accepted write.
- Stale compare: unsigned 64-bit. If TIME+GUARD overflows 2^64, every entry is stale.
- TIME_RESYNC, any state:
  - next cycle all valid bits cleared and state -> IDLE.
  - FLUSHED pulses; pending flag retained; any scan in progress is aborted with no DATA_WR.
  - Resync in the same cycle as ISSUE: the issue completes (DATA_WR=1), then the flush.
- Full: COUNT==DEPTH forces RDY_A/RDY_B low; no entries are overwritten.
- DATA_WR and STALE_DROP never pulse while RESET is high.

Decomposition:
- Package rt_cmd_pkg:
  - cmd_payload_t packed struct with fields in the order above; CMD_PAYLOAD_W.
  - typedef cmd_entry_t {valid, tstart[63:0], payload}.
  - FSM enum sched_state_t {IDLE, SCAN, ISSUE}.
- One sub-module, rt_slot_alloc: priority encoder returning the lowest free slot index and a full flag from the valid vector.

Test Plan:
- Reset, TIME=0: write A TSTART=0x22C0, then write A TSTART=0x92C0; pulse REQ -> DATA_WR after 10 cycles (DEPTH=8) with TIME_START_z=0x22C0; COUNT=1.
- Simultaneous WR_A (0x40020) and WR_B (0x225A5): RDY_B=0 that cycle; B holds and is accepted the next cycle; REQ -> 0x225A5 issued first, next REQ -> 0x40020.
- TIME=0x9000; table holds 0x8000 and 0x9005 (inside GUARD) and 0x65020; REQ -> two STALE_DROP pulses; DATA_WR with 0x65020; COUNT=0.
- Fill 8 slots -> RDY_A=0, COUNT=8; a 9th WR_A is ignored; after one issue, RDY_A=1 again.
- REQ on empty table: no DATA_WR. Write 0x80020 at cycle t -> DATA_WR at t+10 with 0x80020.
- TIME_RESYNC mid-SCAN with 3 entries: no DATA_WR; FLUSHED=1; COUNT=0. Pending is retained, so the next write is issued after DEPTH+2 cycles.
